// File: rtl/bb_pkg.sv
// Shared definitions for the fetch/decode slice: opcode values, instruction
// field widths and the fetch sequencer state encoding.
package bb_pkg;

  localparam int OPC_W   = 3;
  localparam int OPR_W   = 5;
  localparam int INSTR_W = OPC_W + OPR_W;

  localparam logic [OPC_W-1:0] OPC_01   = 3'b001;
  localparam logic [OPC_W-1:0] OPC_10   = 3'b010;
  localparam logic [OPC_W-1:0] OPC_HALT = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_ISSUE,
    ST_HALTED
  } fetch_state_t;

endpackage

// File: rtl/fetch_pc.sv
// Program counter for the fetch stage: clear beats load beats increment,
// and the increment wraps silently at 2^PC_BITS.
module fetch_pc #(
  parameter int PC_BITS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               load,
  input  logic [PC_BITS-1:0] load_value,
  input  logic               incr,
  output logic [PC_BITS-1:0] pc_next
);

  logic [PC_BITS-1:0] pc_q;
  logic [PC_BITS-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (clear) begin
      pc_d = '0;
    end else if (load) begin
      pc_d = load_value;
    end else if (incr) begin
      pc_d = pc_q + PC_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  // The upcoming PC lets the caller register mem_addr in the same edge.
  assign pc_next = pc_d;

endmodule

// File: rtl/fetch.sv
// Instruction fetch sequencer: REQ -> RESP -> ISSUE per instruction, with
// downstream stall, external jump and a HALT opcode that stops fetching.
module fetch
  import bb_pkg::*;
#(
  parameter int ADDRESS_BITS = 5,
  parameter int INSTR_BITS   = 3,
  parameter int PC_BITS      = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             run,
  input  logic                             stall,
  input  logic                             jump_valid,
  input  logic [PC_BITS-1:0]               jump_target,
  output logic [PC_BITS-1:0]               mem_addr,
  output logic                             mem_rd,
  input  logic [INSTR_BITS+ADDRESS_BITS-1:0] mem_data,
  output logic [INSTR_BITS+ADDRESS_BITS-1:0] o_value,
  output logic                             o_enable,
  output logic                             o_busy,
  output logic                             o_halted
);

  localparam int W = INSTR_BITS + ADDRESS_BITS;
  // All-ones opcode is HALT; this equals OPC_HALT at the default widths.
  localparam logic [INSTR_BITS-1:0] HALT_CODE = {INSTR_BITS{1'b1}};

  fetch_state_t     state_q, state_d;
  logic [PC_BITS-1:0] mem_addr_q, mem_addr_d;
  logic             mem_rd_q, mem_rd_d;
  logic [W-1:0]     o_value_q, o_value_d;
  logic             o_enable_q, o_enable_d;
  logic             o_busy_q, o_busy_d;
  logic             o_halted_q, o_halted_d;

  logic             pc_clear;
  logic             pc_load;
  logic             pc_incr;
  logic [PC_BITS-1:0] pc_next;
  logic             resp_is_halt;

  assign resp_is_halt = (mem_data[W-1 -: INSTR_BITS] == HALT_CODE);

  fetch_pc #(
    .PC_BITS(PC_BITS)
  ) u_pc (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pc_clear),
    .load       (pc_load),
    .load_value (jump_target),
    .incr       (pc_incr),
    .pc_next    (pc_next)
  );

  always_comb begin
    state_d    = state_q;
    pc_clear   = 1'b0;
    pc_load    = 1'b0;
    pc_incr    = 1'b0;
    o_value_d  = o_value_q;
    o_enable_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (run) begin
          pc_clear = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        if (jump_valid) begin
          pc_load = 1'b1;
          state_d = ST_REQ;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        // A jump here throws away the returning byte, HALT or not.
        if (jump_valid) begin
          pc_load = 1'b1;
          state_d = ST_REQ;
        end else if (resp_is_halt) begin
          state_d = ST_HALTED;
        end else begin
          o_value_d = mem_data;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (jump_valid) begin
          pc_load    = 1'b1;
          o_enable_d = !stall;
          state_d    = ST_REQ;
        end else if (!stall) begin
          pc_incr    = 1'b1;
          o_enable_d = 1'b1;
          state_d    = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    mem_rd_d   = (state_d == ST_REQ);
    mem_addr_d = pc_next;
    o_busy_d   = (state_d == ST_REQ) || (state_d == ST_RESP) || (state_d == ST_ISSUE);
    o_halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      o_value_q  <= '0;
      o_enable_q <= 1'b0;
      o_busy_q   <= 1'b0;
      o_halted_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      o_value_q  <= o_value_d;
      o_enable_q <= o_enable_d;
      o_busy_q   <= o_busy_d;
      o_halted_q <= o_halted_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_rd   = mem_rd_q;
  assign o_value  = o_value_q;
  assign o_enable = o_enable_q;
  assign o_busy   = o_busy_q;
  assign o_halted = o_halted_q;

endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: expected instruction bytes are queued with the
// stimulus and popped whenever the DUT strobes o_enable.
`timescale 1ns/1ps
module tb_fetch;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       stall = 1'b0;
  logic       jump_valid = 1'b0;
  logic [7:0] jump_target = 8'h00;
  logic [7:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_data = 8'h00;
  logic [7:0] o_value;
  logic       o_enable;
  logic       o_busy;
  logic       o_halted;

  logic [7:0] mem [256];
  logic [7:0] exp_q [$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int last_cyc = 0;
  int prev_cyc = 0;
  logic prev_en = 1'b0;
  int base;

  fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .stall       (stall),
    .jump_valid  (jump_valid),
    .jump_target (jump_target),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_data    (mem_data),
    .o_value     (o_value),
    .o_enable    (o_enable),
    .o_busy      (o_busy),
    .o_halted    (o_halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (prev_en) check("en_b2b", {31'd0, o_enable}, 32'd0);
    if (o_enable) begin
      strobe_cnt++;
      prev_cyc = last_cyc;
      last_cyc = cyc;
      if (exp_q.size() == 0) check("spurious_en", {31'd0, o_enable}, 32'd0);
      else check("strobe_val", {24'd0, o_value}, {24'd0, exp_q.pop_front()});
    end
    prev_en = o_enable;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_run();
    run = 1'b1;
    tick(1);
    run = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    int n = 0;
    while (!o_halted && n < budget) begin
      tick(1);
      n++;
    end
    check("halt_reached", {31'd0, o_halted}, 32'd1);
  endtask

  task automatic wait_req(input logic [7:0] addr, input int budget);
    int n = 0;
    while (!(mem_rd && mem_addr == addr) && n < budget) begin
      tick(1);
      n++;
    end
    check("req_seen", {31'd0, mem_rd}, 32'd1);
    check("req_addr", {24'd0, mem_addr}, {24'd0, addr});
  endtask

  task automatic wait_value(input logic [7:0] v, input int budget);
    int n = 0;
    while (o_value != v && n < budget) begin
      tick(1);
      n++;
    end
    check("value_loaded", {24'd0, o_value}, {24'd0, v});
  endtask

  task automatic wait_strobe(input int budget);
    int n = 0;
    do begin
      tick(1);
      n++;
    end while (!o_enable && n < budget);
    check("strobe_seen", {31'd0, o_enable}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr"}, {24'd0, mem_addr}, 32'd0);
    check({tag, "_rd"}, {31'd0, mem_rd}, 32'd0);
    check({tag, "_val"}, {24'd0, o_value}, 32'd0);
    check({tag, "_en"}, {31'd0, o_enable}, 32'd0);
    check({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    check({tag, "_halt"}, {31'd0, o_halted}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'hE0;

    // Reset state
    tick(2);
    check_all_zero("rst");
    rst_n = 1'b1;
    tick(1);

    // Basic program: two strobes three cycles apart, then HALT
    mem[0] = 8'h21; mem[1] = 8'h45; mem[2] = 8'hE0;
    exp_q.push_back(8'h21); exp_q.push_back(8'h45);
    base = strobe_cnt;
    pulse_run();
    check("busy_after_run", {31'd0, o_busy}, 32'd1);
    wait_halt(40);
    check("t1_strobes", strobe_cnt - base, 2);
    check("t1_gap", last_cyc - prev_cyc, 3);
    check("t1_halt_addr", {24'd0, mem_addr}, 32'h02);
    check("t1_busy", {31'd0, o_busy}, 32'd0);
    tick(5);
    check("t1_no_third", strobe_cnt - base, 2);

    // Stall held in ISSUE for 0x21
    stall = 1'b1;
    base = strobe_cnt;
    pulse_run();
    wait_value(8'h21, 10);
    repeat (4) begin
      check("stall_en", {31'd0, o_enable}, 32'd0);
      check("stall_val", {24'd0, o_value}, 32'h21);
      tick(1);
    end
    exp_q.push_back(8'h21); exp_q.push_back(8'h45);
    stall = 1'b0;
    tick(1);
    check("release_en", {31'd0, o_enable}, 32'd1);
    check("release_addr", {24'd0, mem_addr}, 32'h01);
    wait_halt(40);
    check("t2_strobes", strobe_cnt - base, 2);

    // Jump during RESP of addr 3 drops that byte
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
    mem[4] = 8'h05; mem[5] = 8'h06; mem[8'h10] = 8'h5A;
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    exp_q.push_back(8'h03); exp_q.push_back(8'h5A);
    pulse_run();
    wait_req(8'h03, 30);
    tick(1);
    jump_valid = 1'b1; jump_target = 8'h10;
    tick(1);
    jump_valid = 1'b0;
    check("j_resp_rd", {31'd0, mem_rd}, 32'd1);
    check("j_resp_addr", {24'd0, mem_addr}, 32'h10);
    wait_halt(40);
    check("t3_queue", exp_q.size(), 0);

    // Jump in unstalled ISSUE of addr 5: byte still strobed, resume at 0x40
    mem[8'h40] = 8'h77;
    for (int i = 1; i <= 6; i++) exp_q.push_back(8'(i));
    exp_q.push_back(8'h77);
    pulse_run();
    wait_req(8'h05, 40);
    tick(2);
    jump_valid = 1'b1; jump_target = 8'h40;
    tick(1);
    jump_valid = 1'b0;
    check("j_issue_en", {31'd0, o_enable}, 32'd1);
    check("j_issue_addr", {24'd0, mem_addr}, 32'h40);
    wait_halt(40);
    check("t4_queue", exp_q.size(), 0);

    // PC wrap from 0xFF to 0x00
    mem[0] = 8'h21; mem[1] = 8'h45; mem[2] = 8'hE0; mem[8'hFF] = 8'h33;
    exp_q.push_back(8'h33); exp_q.push_back(8'h21); exp_q.push_back(8'h45);
    pulse_run();
    jump_valid = 1'b1; jump_target = 8'hFF;
    tick(1);
    jump_valid = 1'b0;
    check("wrap_req_addr", {24'd0, mem_addr}, 32'hFF);
    wait_strobe(10);
    check("wrap_addr", {24'd0, mem_addr}, 32'h00);
    wait_halt(40);
    check("t5_queue", exp_q.size(), 0);

    // Reset during RESP aborts everything
    base = strobe_cnt;
    pulse_run();
    tick(1);
    rst_n = 1'b0;
    tick(1);
    check_all_zero("mid_rst");
    rst_n = 1'b1;
    tick(8);
    check("post_rst_strobes", strobe_cnt - base, 0);
    check("post_rst_busy", {31'd0, o_busy}, 32'd0);

    // Jump in IDLE is ignored
    jump_valid = 1'b1; jump_target = 8'h40;
    tick(2);
    jump_valid = 1'b0;
    check("idle_jump_rd", {31'd0, mem_rd}, 32'd0);
    check("idle_jump_busy", {31'd0, o_busy}, 32'd0);
    check("final_queue", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
